// File: rtl/play_line_scan_if.sv
// Request/result bundle between the board-state registers and the line scanner.
// The master issues a board snapshot; the slave (scanner) returns masks and a chosen move.
interface play_line_scan_if #(
   parameter int unsigned N = 3
);
   logic             start;
   logic [N*N-1:0]   ain;
   logic [N*N-1:0]   bin;
   logic             busy;
   logic             done;
   logic             err;
   logic [N*N-1:0]   win_mask;
   logic [N*N-1:0]   block_mask;
   logic [N*N-1:0]   move;
   logic             move_valid;

   modport master (
      output start, ain, bin,
      input  busy, done, err, win_mask, block_mask, move, move_valid
   );

   modport slave (
      input  start, ain, bin,
      output busy, done, err, win_mask, block_mask, move, move_valid
   );
endinterface

// File: rtl/play_line_scan.sv
// Sequential line scanner for an N x N board: one row/column/diagonal per clock, accumulating
// cells that complete a line for A (win) or for B (block), then picks a single move.
module play_line_scan #(
   parameter int unsigned N = 3
) (
   input logic             clk,
   input logic             rst,
   play_line_scan_if.slave bus
);

   localparam int unsigned Cells = N * N;
   localparam int unsigned Lines = 2 * N + 2;
   localparam int unsigned LineW = $clog2(Lines);
   localparam int          Ni    = int'(N);
   localparam logic [3:0]  Need  = 4'(N - 1);

   typedef enum logic [1:0] {StIdle, StScan, StFin} state_e;

   state_e             state_q, state_d;
   logic [LineW-1:0]   line_q, line_d;
   logic [Cells-1:0]   snap_a_q, snap_a_d;
   logic [Cells-1:0]   snap_b_q, snap_b_d;
   logic [Cells-1:0]   win_q, win_d;
   logic [Cells-1:0]   block_q, block_d;
   logic [Cells-1:0]   move_q, move_d;
   logic               err_q, err_d;
   logic               move_valid_q, move_valid_d;

   logic [Cells-1:0]   line_mask, line_a, line_b, line_empty;
   logic [3:0]         a_cnt, b_cnt;
   logic               win_hit, block_hit;

   // Later (lower) indices overwrite earlier ones, leaving the lowest set bit.
   function automatic logic [Cells-1:0] lowest(input logic [Cells-1:0] v);
      logic [Cells-1:0] r;
      r = '0;
      for (int k = Cells - 1; k >= 0; k--) begin
         if (v[k]) begin
            r    = '0;
            r[k] = 1'b1;
         end
      end
      return r;
   endfunction

   // Membership of each cell in the line selected by line_q.
   always_comb begin
      line_mask = '0;
      for (int r = 0; r < Ni; r++) begin
         for (int c = 0; c < Ni; c++) begin
            line_mask[r*Ni+c] = (int'(line_q) == r) ||
                                (int'(line_q) == Ni + c) ||
                                (int'(line_q) == 2 * Ni && r == c) ||
                                (int'(line_q) == 2 * Ni + 1 && r + c == Ni - 1);
         end
      end
   end

   always_comb begin
      line_a     = line_mask & snap_a_q;
      line_b     = line_mask & snap_b_q;
      line_empty = line_mask & ~snap_a_q & ~snap_b_q;
      a_cnt      = '0;
      b_cnt      = '0;
      for (int k = 0; k < Cells; k++) begin
         a_cnt = a_cnt + 4'(line_a[k]);
         b_cnt = b_cnt + 4'(line_b[k]);
      end
      win_hit   = (a_cnt == Need) && (b_cnt == 4'd0);
      block_hit = (b_cnt == Need) && (a_cnt == 4'd0);
   end

   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      snap_a_d     = snap_a_q;
      snap_b_d     = snap_b_q;
      win_d        = win_q;
      block_d      = block_q;
      move_d       = move_q;
      err_d        = err_q;
      move_valid_d = move_valid_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               snap_a_d     = bus.ain;
               snap_b_d     = bus.bin;
               win_d        = '0;
               block_d      = '0;
               move_d       = '0;
               move_valid_d = 1'b0;
               line_d       = '0;
               err_d        = |(bus.ain & bus.bin);
               state_d      = StScan;
            end
         end
         StScan: begin
            // A conflicting snapshot spends one cycle here so done lands one edge later.
            if (err_q) begin
               state_d = StFin;
            end else begin
               if (win_hit) win_d = win_q | line_empty;
               if (block_hit) block_d = block_q | line_empty;
               if (line_q == LineW'(Lines - 1)) begin
                  state_d      = StFin;
                  move_d       = (|win_d) ? lowest(win_d) : lowest(block_d);
                  move_valid_d = |move_d;
               end else begin
                  line_d = line_q + 1'b1;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         line_q       <= '0;
         snap_a_q     <= '0;
         snap_b_q     <= '0;
         win_q        <= '0;
         block_q      <= '0;
         move_q       <= '0;
         err_q        <= 1'b0;
         move_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_q       <= line_d;
         snap_a_q     <= snap_a_d;
         snap_b_q     <= snap_b_d;
         win_q        <= win_d;
         block_q      <= block_d;
         move_q       <= move_d;
         err_q        <= err_d;
         move_valid_q <= move_valid_d;
      end
   end

   assign bus.busy       = (state_q == StScan) && !err_q;
   assign bus.done       = (state_q == StFin);
   assign bus.err        = err_q;
   assign bus.win_mask   = win_q;
   assign bus.block_mask = block_q;
   assign bus.move       = move_q;
   assign bus.move_valid = move_valid_q;

endmodule

// File: tb/tb_play_line_scan.sv
// Bench for play_line_scan: fixed vectors, multi-cycle corner sequences and random boards
// checked against a line-by-line reference model, on N=3 and N=4 instances.
module tb_play_line_scan;

   localparam int FBusy  = 0;
   localparam int FDone  = 1;
   localparam int FErr   = 2;
   localparam int FWin   = 3;
   localparam int FBlock = 4;
   localparam int FMove  = 5;
   localparam int FMv    = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   play_line_scan_if #(.N(3)) bus3 ();
   play_line_scan_if #(.N(4)) bus4 ();

   play_line_scan #(.N(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));
   play_line_scan #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int          n;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] w;
      logic [63:0] bl;
      logic [63:0] mv;
      logic        e;
      int          lat;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] obs(input int n, input int f);
      if (n == 4) begin
         case (f)
            FBusy:   return 64'(bus4.busy);
            FDone:   return 64'(bus4.done);
            FErr:    return 64'(bus4.err);
            FWin:    return 64'(bus4.win_mask);
            FBlock:  return 64'(bus4.block_mask);
            FMove:   return 64'(bus4.move);
            default: return 64'(bus4.move_valid);
         endcase
      end
      case (f)
         FBusy:   return 64'(bus3.busy);
         FDone:   return 64'(bus3.done);
         FErr:    return 64'(bus3.err);
         FWin:    return 64'(bus3.win_mask);
         FBlock:  return 64'(bus3.block_mask);
         FMove:   return 64'(bus3.move);
         default: return 64'(bus3.move_valid);
      endcase
   endfunction

   task automatic drive(input int n, input logic s, input logic [63:0] a, input logic [63:0] b);
      if (n == 4) begin
         bus4.start = s;
         bus4.ain   = a[15:0];
         bus4.bin   = b[15:0];
      end else begin
         bus3.start = s;
         bus3.ain   = a[8:0];
         bus3.bin   = b[8:0];
      end
   endtask

   // Reference: enumerate each line's cell list, count pieces, record the lone empty cell.
   task automatic ref_scan(input int n, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] w, output logic [63:0] bl,
                           output logic [63:0] mv, output logic e);
      int cells[8];
      int na, nb, emp;
      w  = '0;
      bl = '0;
      mv = '0;
      e  = |(a & b);
      if (e) return;
      for (int l = 0; l < 2 * n + 2; l++) begin
         for (int i = 0; i < n; i++) begin
            if (l < n)           cells[i] = l * n + i;
            else if (l < 2 * n)  cells[i] = i * n + (l - n);
            else if (l == 2 * n) cells[i] = i * n + i;
            else                 cells[i] = i * n + (n - 1 - i);
         end
         na  = 0;
         nb  = 0;
         emp = 0;
         for (int i = 0; i < n; i++) begin
            if (a[cells[i]])      na++;
            else if (b[cells[i]]) nb++;
            else                  emp = cells[i];
         end
         if (na == n - 1 && nb == 0) w[emp] = 1'b1;
         if (nb == n - 1 && na == 0) bl[emp] = 1'b1;
      end
      mv = (w != 0) ? (w & (~w + 64'd1)) : (bl & (~bl + 64'd1));
   endtask

   task automatic run_scan(input int n, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] ew, input logic [63:0] eb, input logic [63:0] em,
                           input logic ee, input int elat, input string tag);
      int lat;
      logic [63:0] mask;
      mask = (64'd1 << (n * n)) - 64'd1;
      @(negedge clk);
      drive(n, 1'b1, a, b);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) begin
            // Scrambled inputs after the start edge must not disturb the scan.
            drive(n, 1'b0, ~a & mask, ~b & mask);
            check({tag, " busy"}, obs(n, FBusy), 64'(!ee));
            check({tag, " err early"}, obs(n, FErr), 64'(ee));
         end
         if (obs(n, FDone) == 64'd1) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, 64'(lat), 64'(elat));
      if (lat >= 0) begin
         check({tag, " err"}, obs(n, FErr), 64'(ee));
         check({tag, " win"}, obs(n, FWin), ew);
         check({tag, " block"}, obs(n, FBlock), eb);
         check({tag, " move"}, obs(n, FMove), em);
         check({tag, " move_valid"}, obs(n, FMv), 64'(em != 0));
         @(negedge clk);
         check({tag, " done drop"}, obs(n, FDone), 64'd0);
         check({tag, " move hold"}, obs(n, FMove), em);
      end
   endtask

   initial begin
      int dones, k1, k2;
      logic [63:0] ra, rb, rw, rbl, rmv, mask;
      logic re;
      int n;

      tbl[0] = '{3, 64'h003, 64'h000, 64'h004, 64'h000, 64'h004, 1'b0, 8};
      tbl[1] = '{3, 64'h000, 64'h110, 64'h000, 64'h001, 64'h001, 1'b0, 8};
      tbl[2] = '{3, 64'h018, 64'h003, 64'h020, 64'h004, 64'h020, 1'b0, 8};
      tbl[3] = '{3, 64'h001, 64'h001, 64'h000, 64'h000, 64'h000, 1'b1, 1};
      tbl[4] = '{3, 64'h003, 64'h000, 64'h004, 64'h000, 64'h004, 1'b0, 8};
      tbl[5] = '{4, 64'h0007, 64'h1000, 64'h0008, 64'h0000, 64'h0008, 1'b0, 10};
      tbl[6] = '{3, 64'h15A, 64'h0A5, 64'h000, 64'h000, 64'h000, 1'b0, 8};
      tbl[7] = '{4, 64'h0000, 64'h8420, 64'h0000, 64'h0001, 64'h0001, 1'b0, 10};

      rst = 1'b1;
      drive(3, 1'b0, 64'd0, 64'd0);
      drive(4, 1'b0, 64'd0, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int f = FBusy; f <= FMv; f++) begin
         check($sformatf("reset n3 f%0d", f), obs(3, f), 64'd0);
         check($sformatf("reset n4 f%0d", f), obs(4, f), 64'd0);
      end

      for (int i = 0; i < 8; i++) begin
         run_scan(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].bl, tbl[i].mv, tbl[i].e,
                  tbl[i].lat, $sformatf("vec%0d", i));
      end

      // Reset during the 4th scan cycle.
      @(negedge clk);
      drive(3, 1'b1, 64'h003, 64'h000);
      @(negedge clk);
      drive(3, 1'b0, 64'h000, 64'h000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int f = FBusy; f <= FMv; f++) check($sformatf("midscan reset f%0d", f), obs(3, f), 64'd0);
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus3.done) dones++;
      end
      check("no done after reset", 64'(dones), 64'd0);

      // A second start mid-scan is ignored.
      drive(3, 1'b1, 64'h003, 64'h000);
      @(negedge clk);
      drive(3, 1'b0, 64'h000, 64'h000);
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         if (k == 3) drive(3, 1'b1, 64'h0C0, 64'h000);
         if (k == 4) drive(3, 1'b0, 64'h000, 64'h000);
         @(negedge clk);
         if (bus3.done) dones++;
      end
      check("single done", 64'(dones), 64'd1);
      check("ignored start win", obs(3, FWin), 64'h004);

      // Start held high: next scan begins on the first idle cycle after done.
      drive(3, 1'b1, 64'h018, 64'h003);
      k1 = -1;
      k2 = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus3.done) begin
            if (k1 < 0) k1 = k;
            else if (k2 < 0) k2 = k;
         end
      end
      check("held first done", 64'(k1), 64'd8);
      check("held spacing", 64'(k2 - k1), 64'd10);
      check("held win", obs(3, FWin), 64'h020);
      drive(3, 1'b0, 64'h000, 64'h000);
      repeat (15) @(negedge clk);

      for (int i = 0; i < 150; i++) begin
         n    = (i % 3 == 2) ? 4 : 3;
         mask = (64'd1 << (n * n)) - 64'd1;
         ra   = 64'($urandom & $urandom) & mask;
         rb   = 64'($urandom & $urandom) & mask & ~ra;
         if (i % 11 == 0) rb = rb | (ra & (~ra + 64'd1));
         ref_scan(n, ra, rb, rw, rbl, rmv, re);
         run_scan(n, ra, rb, rw, rbl, rmv, re, re ? 1 : 2 * n + 2, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
